// File: rtl/melody_sequencer_if.sv
// Control/score-write bus and tone-generator outputs of the melody sequencer.
// The master is the controlling logic; the slave is the sequencer itself.
interface melody_sequencer_if;
   logic        start;
   logic        stop;
   logic        loop;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [13:0] wr_data;
   logic [14:0] half_period;
   logic        tone_en;
   logic        note_start;
   logic [3:0]  note_idx;
   logic        busy;
   logic        done;

   modport master (
      output start, stop, loop, wr_en, wr_addr, wr_data,
      input  half_period, tone_en, note_start, note_idx, busy, done
   );

   modport slave (
      input  start, stop, loop, wr_en, wr_addr, wr_data,
      output half_period, tone_en, note_start, note_idx, busy, done
   );
endinterface

// File: rtl/melody_sequencer.sv
// Plays a 16-entry score onto a square-wave tone generator: each entry drives a
// pitch for dur ticks, then an optional silent gap, then the next entry.
module melody_sequencer #(
   parameter int FREQ_CLK    = 12000000,
   parameter int TICK_CYCLES = 12000,
   parameter int GAP_TICKS   = 20
) (
   input  logic               clk,
   input  logic               rst,
   melody_sequencer_if.slave  sq
);

   localparam int              CW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CW-1:0]   CYC_LAST = CW'(TICK_CYCLES - 1);
   localparam logic [7:0]      GAP_LAST = 8'(GAP_TICKS - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP} state_t;

   // Note frequencies in millihertz so the divide stays integral and truncates.
   function automatic logic [14:0] pitch_calc(input int note);
      logic [63:0] mhz;
      logic [63:0] fclk;
      fclk = 64'(FREQ_CLK);
      case (note)
         1:       mhz = 64'd261626;
         2:       mhz = 64'd277183;
         3:       mhz = 64'd293665;
         4:       mhz = 64'd311127;
         5:       mhz = 64'd329628;
         6:       mhz = 64'd349228;
         7:       mhz = 64'd369994;
         8:       mhz = 64'd391995;
         9:       mhz = 64'd415305;
         10:      mhz = 64'd440000;
         11:      mhz = 64'd466164;
         12:      mhz = 64'd493883;
         default: mhz = 64'd0;
      endcase
      if (mhz == 64'd0) return 15'd0;
      return 15'((fclk * 64'd1000) / (64'd2 * mhz));
   endfunction

   logic [14:0] pitch_tab [16];

   for (genvar gi = 0; gi < 16; gi++) begin : g_pitch
      localparam logic [14:0] PITCH = pitch_calc(gi);
      assign pitch_tab[gi] = PITCH;
   end

   logic [13:0]   score_q [16];
   logic [13:0]   score_d [16];
   state_t        state_q, state_d;
   logic [3:0]    addr_q, addr_d;
   logic [7:0]    tick_q, tick_d;
   logic [CW-1:0] cyc_q, cyc_d;
   logic [7:0]    dur_q, dur_d;
   logic [14:0]   half_period_q, half_period_d;
   logic          tone_en_q, tone_en_d;
   logic          note_start_q, note_start_d;
   logic [3:0]    note_idx_q, note_idx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [13:0] fetch_entry;
   logic [1:0]  fetch_oct;
   logic [3:0]  fetch_note;
   logic [7:0]  fetch_dur;
   logic        fetch_rest;
   logic        cyc_last;
   logic        play_last;
   logic        gap_last;
   logic        advance;

   assign fetch_entry = score_q[addr_q];
   assign fetch_oct   = fetch_entry[13:12];
   assign fetch_note  = fetch_entry[11:8];
   assign fetch_dur   = fetch_entry[7:0];
   assign fetch_rest  = (fetch_note == 4'd0) || (fetch_note > 4'd12);
   assign cyc_last    = (cyc_q == CYC_LAST);
   assign play_last   = cyc_last && (tick_q == dur_q - 8'd1);
   assign gap_last    = cyc_last && (tick_q == GAP_LAST);

   always_comb begin
      score_d = score_q;
      if (sq.wr_en) score_d[sq.wr_addr] = sq.wr_data;
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      tick_d        = tick_q;
      cyc_d         = cyc_q;
      dur_d         = dur_q;
      half_period_d = half_period_q;
      tone_en_d     = tone_en_q;
      note_start_d  = 1'b0;
      note_idx_d    = note_idx_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      advance       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (sq.start && !sq.stop) begin
               state_d = S_FETCH;
               addr_d  = 4'd0;
               busy_d  = 1'b1;
               cyc_d   = '0;
               tick_d  = 8'd0;
            end
         end
         S_FETCH: begin
            cyc_d  = '0;
            tick_d = 8'd0;
            if (fetch_dur != 8'd0) begin
               state_d       = S_PLAY;
               dur_d         = fetch_dur;
               note_start_d  = 1'b1;
               note_idx_d    = addr_q;
               tone_en_d     = !fetch_rest;
               half_period_d = fetch_rest ? 15'd0 : (pitch_tab[fetch_note] >> fetch_oct);
            end else if ((addr_q != 4'd0) && sq.loop) begin
               addr_d = 4'd0;
            end else begin
               // An end marker at address 0 means an empty score: never loop on it.
               state_d = S_IDLE;
               addr_d  = 4'd0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         S_PLAY, S_GAP: begin
            if (cyc_last) begin
               cyc_d  = '0;
               tick_d = tick_q + 8'd1;
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
            if (state_q == S_PLAY && play_last) begin
               tone_en_d = 1'b0;
               cyc_d     = '0;
               tick_d    = 8'd0;
               if (GAP_TICKS == 0) advance = 1'b1;
               else                state_d = S_GAP;
            end else if (state_q == S_GAP && gap_last) begin
               cyc_d   = '0;
               tick_d  = 8'd0;
               advance = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Leaving entry 15 counts as reaching the end of the score.
      if (advance) begin
         if ((addr_q == 4'hF) && !sq.loop) begin
            state_d = S_IDLE;
            addr_d  = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end else begin
            state_d = S_FETCH;
            addr_d  = addr_q + 4'd1;
         end
      end

      if (sq.stop && (state_q != S_IDLE)) begin
         state_d   = S_IDLE;
         addr_d    = 4'd0;
         cyc_d     = '0;
         tick_d    = 8'd0;
         tone_en_d = 1'b0;
         busy_d    = 1'b0;
         done_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) score_q[i] <= 14'd0;
         state_q       <= S_IDLE;
         addr_q        <= 4'd0;
         tick_q        <= 8'd0;
         cyc_q         <= '0;
         dur_q         <= 8'd0;
         half_period_q <= 15'd0;
         tone_en_q     <= 1'b0;
         note_start_q  <= 1'b0;
         note_idx_q    <= 4'd0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         score_q       <= score_d;
         state_q       <= state_d;
         addr_q        <= addr_d;
         tick_q        <= tick_d;
         cyc_q         <= cyc_d;
         dur_q         <= dur_d;
         half_period_q <= half_period_d;
         tone_en_q     <= tone_en_d;
         note_start_q  <= note_start_d;
         note_idx_q    <= note_idx_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign sq.half_period = half_period_q;
   assign sq.tone_en     = tone_en_q;
   assign sq.note_start  = note_start_q;
   assign sq.note_idx    = note_idx_q;
   assign sq.busy        = busy_q;
   assign sq.done        = done_q;

endmodule
